// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: FSM states, default widths and state-to-output decode for ram_req_ctrl
package ram_ctrl_pkg;
  localparam int N_DEF = 8;
  localparam int AW_DEF = 10;
  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_CAP, RSP} state_e;
  typedef struct packed {
    logic req_ready;
    logic rsp_valid;
    logic cs;
    logic en;
    logic rws;
    logic drive;
  } ctrl_t;
  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c.req_ready = s == IDLE;
    c.rsp_valid = s == RSP;
    c.cs        = s == WR || s == RD_ADDR || s == RD_CAP;
    c.en        = c.cs;
    c.rws       = s == WR;
    c.drive     = s == WR;
    return c;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: 16-bit up-counter that sticks at 0xFFFF, with synchronous clear
module sat_counter (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= clr_i ? 16'h0 : (inc_i && cnt_q != 16'hFFFF) ? cnt_q + 16'h1 : cnt_q;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready request front-end sequencing single-port RAM writes and two-cycle reads
module ram_req_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_rdata,
  output logic [AW-1:0] ram_addr,
  inout  wire  [N-1:0]  ram_data,
  output logic          ram_cs,
  output logic          ram_en,
  output logic          ram_rws,
  output logic [15:0]   wr_count,
  output logic [15:0]   rd_count
);
  state_e        state_q, state_d;
  ctrl_t         ctrl_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q, rdata_q;
  always_comb
    state_d = state_q == IDLE    ? (req_valid ? (req_we ? WR : RD_ADDR) : IDLE) :
              state_q == WR      ? IDLE :
              state_q == RD_ADDR ? RD_CAP :
              state_q == RD_CAP  ? RSP :
              rsp_ready          ? IDLE : RSP;
  // outputs are registered alongside the state so they stay a pure decode of it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= ctrl_of(IDLE);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD_CAP) rdata_q <= ram_data;
    end
  end
  assign ram_data  = ctrl_q.drive ? wdata_q : {N{1'bz}};
  assign req_ready = ctrl_q.req_ready;
  assign rsp_valid = ctrl_q.rsp_valid;
  assign rsp_rdata = rdata_q;
  assign ram_addr  = addr_q;
  assign ram_cs    = ctrl_q.cs;
  assign ram_en    = ctrl_q.en;
  assign ram_rws   = ctrl_q.rws;
  sat_counter u_wr_cnt (.clk(clk), .clr_i(rst), .inc_i(state_q == WR), .cnt_o(wr_count));
  sat_counter u_rd_cnt (.clk(clk), .clr_i(rst), .inc_i(state_q == RD_CAP), .cnt_o(rd_count));
endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb_ram_req_ctrl: directed scenarios for ram_req_ctrl against a behavioural 1K x 8 RAM
module tb_ram_req_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic [9:0]  ram_addr;
  wire  [7:0]  ram_data;
  logic        ram_cs, ram_en, ram_rws;
  logic [15:0] wr_count, rd_count;
  logic [7:0]  mem [0:1023];
  int          n_cmp = 0;
  int          n_err = 0;

  ram_req_ctrl #(.N(8), .AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_en(ram_en), .ram_rws(ram_rws),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  // RAM model: drives the bus only for reads, writes on the closing edge
  assign ram_data = (ram_cs && ram_en && !ram_rws) ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_cs && ram_en && ram_rws) mem[ram_addr] <= ram_data;

  // during reads the bus must carry exactly the RAM's value, never a mix with controller data
  always @(negedge clk) if (!rst && ram_cs && ram_en && !ram_rws) begin
    n_cmp++;
    if (ram_data !== mem[ram_addr]) begin
      n_err++;
      $display("FAIL bus_contention addr=%h got=%h want=%h", ram_addr, ram_data, mem[ram_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [9:0] a, output logic [7:0] d, output int lat);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    d = rsp_rdata;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = 8'h55;
    tick();
    tick();
    rst = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, ram_cs, ram_en, ram_rws} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctrl got=%b want=10000", {req_ready, rsp_valid, ram_cs, ram_en, ram_rws});
    end
    n_cmp++;
    if (rsp_rdata !== 8'h00 || ram_addr !== 10'h000) begin
      n_err++;
      $display("FAIL reset_data rdata=%h addr=%h want 00/000", rsp_rdata, ram_addr);
    end
    n_cmp++;
    if (wr_count !== 16'h0 || rd_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_counts wr=%h rd=%h want 0/0", wr_count, rd_count);
    end
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || ram_cs !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ignores_req ready=%b cs=%b want 1/0", req_ready, ram_cs);
    end
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h001; req_wdata = 8'h10;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if ({req_ready, ram_cs, ram_en, ram_rws} !== 4'b0111 || ram_addr !== 10'h001 || ram_data !== 8'h10) begin
      n_err++;
      $display("FAIL wr_cycle ctrl=%b addr=%h data=%h want 0111/001/10", {req_ready, ram_cs, ram_en, ram_rws}, ram_addr, ram_data);
    end
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || ram_cs !== 1'b0 || ram_addr !== 10'h001 || wr_count !== 16'd1) begin
      n_err++;
      $display("FAIL wr_done ready=%b cs=%b addr=%h wr=%h want 1/0/001/1", req_ready, ram_cs, ram_addr, wr_count);
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h001;
    tick();
    req_valid = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, ram_cs, ram_en, ram_rws} !== 5'b00110) begin
      n_err++;
      $display("FAIL rd_addr_cycle got=%b want=00110", {req_ready, rsp_valid, ram_cs, ram_en, ram_rws});
    end
    tick();
    n_cmp++;
    if ({req_ready, rsp_valid, ram_cs, ram_en, ram_rws} !== 5'b00110) begin
      n_err++;
      $display("FAIL rd_cap_cycle got=%b want=00110", {req_ready, rsp_valid, ram_cs, ram_en, ram_rws});
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h10 || rd_count !== 16'd1 || ram_cs !== 1'b0) begin
      n_err++;
      $display("FAIL rd_rsp valid=%b data=%h rd=%h cs=%b want 1/10/1/0", rsp_valid, rsp_rdata, rd_count, ram_cs);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_handshake ready=%b valid=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] a [3] = '{10'h002, 10'h005, 10'h010};
    logic [7:0] d [3] = '{8'h20, 8'h35, 8'h70};
    logic [7:0] r;
    int         lat;
    req_valid = 1'b1; req_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = a[i]; req_wdata = d[i];
      n_cmp++;
      if (req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready_hi[%0d] got=%b want=1", i, req_ready);
      end
      tick();
      n_cmp++;
      if (req_ready !== 1'b0 || ram_rws !== 1'b1 || ram_addr !== a[i] || ram_data !== d[i]) begin
        n_err++;
        $display("FAIL b2b_wr[%0d] ready=%b rws=%b addr=%h data=%h want 0/1/%h/%h", i, req_ready, ram_rws, ram_addr, ram_data, a[i], d[i]);
      end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++;
    if (wr_count !== 16'd4) begin
      n_err++;
      $display("FAIL b2b_wr_count got=%h want=4", wr_count);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(a[i], r, lat);
      n_cmp++;
      if (r !== d[i] || lat !== 3) begin
        n_err++;
        $display("FAIL b2b_read[%0d] data=%h lat=%0d want %h/3", i, r, lat, d[i]);
      end
    end
  endtask

  task automatic test_rsp_stall();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h002;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h20 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall[%0d] valid=%b data=%h ready=%b want 1/20/0", i, rsp_valid, rsp_rdata, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rd_count !== 16'd5) begin
      n_err++;
      $display("FAIL stall_release ready=%b valid=%b rd=%h want 1/0/5", req_ready, rsp_valid, rd_count);
    end
  endtask

  task automatic test_reset_rdcap();
    logic seen = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h005;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rd_count !== 16'd0 || ram_cs !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rdcap ready=%b valid=%b rd=%h cs=%b want 1/0/0/0", req_ready, rsp_valid, rd_count, ram_cs);
    end
    for (int i = 0; i < 6; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0 || rd_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_rdcap_no_rsp seen=%b rd=%h want 0/0", seen, rd_count);
    end
  endtask

  task automatic test_read_then_write();
    logic [7:0] r;
    int         lat;
    do_read(10'h010, r, lat);
    n_cmp++;
    if (r !== 8'h70 || lat !== 3) begin
      n_err++;
      $display("FAIL rtw_read data=%h lat=%0d want 70/3", r, lat);
    end
    do_write(10'h3FF, 8'hA5);
    do_read(10'h3FF, r, lat);
    n_cmp++;
    if (r !== 8'hA5 || wr_count !== 16'd1 || rd_count !== 16'd2) begin
      n_err++;
      $display("FAIL rtw_top_addr data=%h wr=%h rd=%h want A5/1/2", r, wr_count, rd_count);
    end
  endtask

  task automatic test_saturate();
    force dut.u_wr_cnt.cnt_q = 16'hFFFE;
    #1;
    release dut.u_wr_cnt.cnt_q;
    do_write(10'h020, 8'h01);
    n_cmp++;
    if (wr_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_first got=%h want=FFFF", wr_count);
    end
    do_write(10'h021, 8'h02);
    do_write(10'h022, 8'h03);
    n_cmp++;
    if (wr_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_hold got=%h want=FFFF", wr_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rsp_stall();
    test_reset_rdcap();
    test_read_then_write();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_req_ctrl.md
RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

Interface
REQ-001 Parameters SHALL be: N, default 8, data width in bits; AW, default 10, address width in bits (1K words).
REQ-002 Timing and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  AW  word address.
REQ-009 req_wdata  input  N  write data.
REQ-010 rsp_valid  output  1  read data available.
REQ-011 rsp_ready  input  1  consumer takes read data.
REQ-012 rsp_rdata  output  N  read data, registered.
REQ-013 ram_addr  output  AW  drives RAM IN_DEC.
REQ-014 ram_data  inout  N  shared bus to RAM INOUT.
REQ-015 ram_cs, ram_en, ram_rws  output  1 each  RAM chip select, enable, read/write select (1 = write).
REQ-016 wr_count, rd_count  output  16 each  completed-operation counters.

Function
REQ-017 The FSM SHALL have the states IDLE, WR, RD_ADDR, RD_CAP and RSP; all outputs SHALL be Moore, decoded from registered state.
REQ-018 IDLE: req_ready=1; on req_valid the controller SHALL latch addr, wdata and we, then go to WR if we=1, else to RD_ADDR.
REQ-019 req_ready SHALL be 0 in every state other than IDLE; acceptance occurs only when req_valid and req_ready are both high at a rising edge.
REQ-020 WR (exactly 1 cycle): ram_cs=ram_en=ram_rws=1, ram_addr=latched addr, ram_data driven with latched wdata; the RAM writes at the closing edge; next state IDLE; wr_count increments.
REQ-021 RD_ADDR (1 cycle): ram_cs=ram_en=1, ram_rws=0, ram_addr=latched addr, ram_data released to hi-Z; next state RD_CAP.
REQ-022 RD_CAP (1 cycle): same RAM controls as RD_ADDR; ram_data SHALL be sampled into rsp_rdata at the closing edge; next state RSP; rd_count increments.
REQ-023 RSP: rsp_valid=1 and rsp_rdata stable until the handshake; ram_cs=ram_en=0; on rsp_ready go to IDLE.
REQ-024 Latency, with acceptance in cycle 0: write SHALL occupy cycle 1 and req_ready SHALL be 1 again in cycle 2; read SHALL set rsp_valid=1 from cycle 3.
REQ-025 ram_data SHALL be driven only in WR and SHALL be hi-Z in all other states, so the RSP cycle provides read-to-write bus turnaround.
REQ-026 In IDLE: ram_cs=ram_en=ram_rws=0 and ram_addr holds its last value.
REQ-027 The counters SHALL saturate at 0xFFFF with no wrap.
REQ-028 Address 2^AW-1 SHALL be handled like any other address; there is no address checking.
REQ-029 Back-to-back writes SHALL sustain 1 write per 2 cycles.

Reset
REQ-030 On rst, at the next edge: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, ram_cs=ram_en=ram_rws=0, ram_addr=0, ram_data hi-Z, wr_count=rd_count=0.
REQ-031 rst SHALL take priority over every transition; an in-flight request SHALL be dropped with no response and no counter update.
REQ-032 req_valid SHALL be ignored during any cycle in which rst=1.

Structure
REQ-033 Package ram_ctrl_pkg SHALL hold the FSM state enumeration and the default N/AW constants.
REQ-034 One sub-module, sat_counter (16-bit, increment enable, synchronous clear), SHALL be instantiated twice.
REQ-035 The tristate driver SHALL be a single continuous assignment in the top level.

Verification
REQ-036 Write 0x001<=0x10, then read 0x001 -> rsp_valid in cycle 3 after acceptance, rsp_rdata=0x10, wr_count=1, rd_count=1.
REQ-037 Writes 0x002<=0x20, 0x005<=0x35, 0x010<=0x70 back-to-back; reads in order -> 0x20, 0x35, 0x70; req_ready toggles 1/0 every cycle during the writes.
REQ-038 Read 0x002 with rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, rsp_rdata=0x20 stable, req_ready=0, then IDLE the cycle after rsp_ready=1.
REQ-039 Assert rst in RD_CAP -> next cycle IDLE, rsp_valid=0, rd_count=0, ram_cs=0; no response ever appears.
REQ-040 Read followed immediately by a write -> ram_data is never driven by the controller while ram_rws=0 (bus-contention checker), and the write lands correctly.
REQ-041 Force wr_count to 0xFFFE, perform 3 writes -> wr_count=0xFFFF.
